// File: rtl/rr_sample_arbiter.sv
// Round-robin arbiter sharing one registered data-bit sample path between NREQ requesters.
// Optional hold-timeout preemption is compiled in when ARB_TIMEOUT_EN is defined.
module rr_sample_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         din,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    out_data,
    output logic                    out_valid,
    output logic                    busy
);
    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [IDW:0]   NREQ_W  = IDW1'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            timeout_hit;

    // Rotate requests so bit 0 is the requester at ptr; the first set bit is the winner offset.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      win_sum;
    logic [IDW-1:0]    winner;
    logic [NREQ-1:0]   win_onehot;
    logic              req_cur;
    logic              din_cur;

    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> ptr_q);

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    assign win_sum = {1'b0, ptr_q} + {1'b0, off};
    assign winner  = (win_sum >= NREQ_W) ? IDW'(win_sum - NREQ_W) : win_sum[IDW-1:0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (winner == IDW'(gi));
    end

    assign req_cur = req[gnt_id_q];
    assign din_cur = din[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int            HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    // Preempt only once the limit is reached and someone else is actually waiting.
    assign timeout_hit = (hold_q == HOLD_LAST) && ((req & ~gnt_q) != '0);

    always_comb begin
        hold_d = '0;
        if (state_q == ST_GRANT) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // Without the timeout path MAX_HOLD has no effect on behaviour.
    assign timeout_hit = 1'b0 & (MAX_HOLD > 0);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        gnt_d       = gnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (req != '0) begin
                    state_d  = ST_GRANT;
                    gnt_d    = win_onehot;
                    gnt_id_d = winner;
                end
            end
            ST_GRANT: begin
                out_valid_d = req_cur;
                if (req_cur) begin
                    out_data_d = din_cur;
                end
                if (!req_cur || timeout_hit) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                out_valid_d = 1'b0;
                gnt_d       = '0;
                ptr_d       = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_id_q    <= '0;
            gnt_q       <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_id_q    <= gnt_id_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rr_sample_arbiter.sv
// Bench for rr_sample_arbiter: directed scenarios plus random traffic against an ownership-level model.
module tb_rr_sample_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       out_data;
    logic       out_valid;
    logic       busy;

    always #5 clk = ~clk;

    rr_sample_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Model: who owns the path, how long it has owned it, and how many dead cycles remain.
    int   m_owner;
    int   m_last_id;
    int   m_ptr;
    int   m_held;
    int   m_cool;
    logic m_valid;
    logic m_data;

    logic [3:0] hist [0:39];
    int         hlen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_update(input logic [3:0] r, input logic [3:0] d, input logic rs);
        int  w;
        bit  found;
        if (!rs) begin
            m_owner = -1; m_last_id = 0; m_ptr = 0; m_held = 0; m_cool = 0;
            m_valid = 1'b0; m_data = 1'b0;
        end else if (m_owner >= 0) begin
            m_valid = r[m_owner];
            if (r[m_owner]) m_data = d[m_owner];
            m_held++;
            if (!r[m_owner] ||
                (TMO && m_held >= MAX_HOLD && (r & ~(4'(1) << m_owner)) != 4'b0)) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            found = 1'b0;
            w = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && r[(m_ptr + k) % NREQ]) begin
                    w = (m_ptr + k) % NREQ;
                    found = 1'b1;
                end
            end
            if (found) begin
                m_owner   = w;
                m_last_id = w;
                m_held    = 0;
                $display("cycle %0d: grant to id %0d", cycle + 1, w);
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0;
        check_val("gnt", gnt, exp_gnt);
        check_val("gnt_id", gnt_id, m_last_id);
        check_val("out_valid", out_valid, m_valid);
        check_val("out_data", out_data, m_data);
        check_val("busy", busy, (m_owner >= 0 || m_cool > 0));
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
        req = r; din = d; rst = rs;
        @(posedge clk);
        model_update(r, d, rs);
        @(negedge clk);
        cycle++;
        compare_all();
    endtask

    task automatic reset_dut();
        step(4'b0, 4'b0, 1'b0);
        step(4'b0, 4'b0, 1'b0);
    endtask

    function automatic int run_from(input int s, input logic [3:0] v);
        int  n;
        bit  stop;
        n = 0;
        stop = 1'b0;
        for (int i = s; i < hlen; i++) begin
            if (!stop && hist[i] == v) n++;
            else stop = 1'b1;
        end
        return n;
    endfunction

    int         order [0:4];
    int         exp_order [0:4] = '{0, 1, 2, 3, 0};
    int         n_grants;
    logic [3:0] prev_gnt;
    logic [3:0] r;
    logic [3:0] rr;

    initial begin
        rst = 1'b0; req = 4'b0; din = 4'b0;
        @(negedge clk);

        // Reset held with every requester asking.
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 4'b0, 1'b0);
            check_val("rst_gnt", gnt, 4'b0);
            check_val("rst_busy", busy, 1'b0);
        end
        step(4'b1111, 4'b0, 1'b1);
        check_val("rst_first_gnt", gnt, 4'b0001);

        // Single requester: latency, data capture, release dead time.
        reset_dut();
        step(4'b0100, 4'b0100, 1'b1);
        check_val("single_gnt", gnt, 4'b0100);
        check_val("single_id", gnt_id, 2);
        step(4'b0100, 4'b0100, 1'b1);
        check_val("single_valid", out_valid, 1'b1);
        check_val("single_data", out_data, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        check_val("single_rel_gnt", gnt, 4'b0);
        check_val("single_rel_valid", out_valid, 1'b0);
        step(4'b0100, 4'b0000, 1'b1);
        check_val("single_dead1", gnt, 4'b0);
        step(4'b0100, 4'b0000, 1'b1);
        check_val("single_regrant", gnt, 4'b0100);

        // Rotation: each grantee drops two cycles after its grant, re-raises in release.
        reset_dut();
        n_grants = 0;
        prev_gnt = 4'b0;
        for (int c = 0; c < 40; c++) begin
            if (n_grants < 5) begin
                r = 4'b1111;
                if (m_owner >= 0 && m_held >= 2) r = r & ~(4'(1) << m_owner);
                step(r, 4'($urandom), 1'b1);
                if (gnt != 4'b0 && prev_gnt == 4'b0) begin
                    order[n_grants] = gnt_id;
                    n_grants++;
                end
                prev_gnt = gnt;
            end
        end
        check_val("rot_count", n_grants, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < n_grants) check_val("rot_order", order[k], exp_order[k]);
        end

        // Two permanent requesters: timeout preemption or indefinite hold.
        reset_dut();
        hlen = 30;
        for (int c = 0; c < hlen; c++) begin
            step(4'b0011, 4'($urandom), 1'b1);
            hist[c] = gnt;
        end
        check_val("tmo_first", hist[0], 4'b0001);
        if (TMO) begin
            check_val("tmo_run0", run_from(0, 4'b0001), 4);
            check_val("tmo_gap", run_from(4, 4'b0000), 2);
            check_val("tmo_run1", run_from(6, 4'b0010), 4);
        end else begin
            check_val("hold_run0", run_from(0, 4'b0001), 30);
        end

        // Lone requester is never preempted.
        reset_dut();
        hlen = 20;
        for (int c = 0; c < hlen; c++) begin
            step(4'b0001, 4'($urandom), 1'b1);
            hist[c] = gnt;
        end
        check_val("lone_run", run_from(0, 4'b0001), 20);

        // Reset mid-grant clears the pointer: id 2 wins over id 3 afterwards.
        reset_dut();
        step(4'b0100, 4'b0, 1'b1);
        step(4'b0000, 4'b0, 1'b1);
        step(4'b0000, 4'b0, 1'b1);
        step(4'b0000, 4'b0, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        check_val("mid_pre_valid", out_valid, 1'b1);
        step(4'b1100, 4'b1100, 1'b0);
        check_val("mid_rst_gnt", gnt, 4'b0);
        check_val("mid_rst_data", out_data, 1'b0);
        step(4'b1100, 4'b1100, 1'b1);
        check_val("mid_after_id", gnt_id, 2);
        check_val("mid_after_gnt", gnt, 4'b0100);

        // Random sticky requests with occasional reset.
        rr = 4'b0;
        for (int c = 0; c < 800; c++) begin
            rr = rr ^ (4'($urandom) & 4'($urandom));
            step(rr, 4'($urandom), ($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_sample_arbiter.md
# rr_sample_arbiter

Round-robin controller that shares one registered sample path between NREQ requesters. It arbitrates the requests, grants one requester at a time, and registers that requester's data bit onto a single output with a valid flag. An optional hold timeout preempts a grant once it has run its limit and another requester is waiting. The block sits in front of the top-level registered output stage.

## Interface
- NREQ, 4, number of requesters (2..16)
- MAX_HOLD, 8, maximum granted cycles before preemption (≥2; used only with ARB_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request level
- din  in  NREQ  per-requester data bit
- gnt  out  NREQ  one-hot grant, registered
- gnt_id  out  $clog2(NREQ)  index of current/last grantee, registered
- out_data  out  1  registered data of the granted requester
- out_valid  out  1  out_data valid this cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, GRANT, RELEASE. Round-robin pointer ptr, reset 0.
- IDLE:
  - If req != 0, the winner is the first set bit of req searching from ptr upward, wrapping at NREQ.
  - Transition to GRANT; gnt <= onehot(winner); gnt_id <= winner; hold_cnt <= 0.
  - If req == 0, stay in IDLE.
- GRANT:
  - Each cycle, out_valid <= req[gnt_id]. If req[gnt_id]=1, out_data <= din[gnt_id]; otherwise out_data holds its value.
  - req[gnt_id]=0 → RELEASE; gnt <= 0.
  - Timeout (ARB_TIMEOUT_EN only): hold_cnt == MAX_HOLD-1 and (req & ~gnt) != 0 → RELEASE; gnt <= 0.
  - Otherwise stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1.
- RELEASE:
  - gnt = 0; out_valid <= 0; out_data holds.
  - ptr <= (gnt_id+1) mod NREQ. Unconditional transition to IDLE.
- gnt is always one-hot or zero. Never more than one bit set.
- Reset (rst=0 at a clock edge), from any state including mid-grant, sets:
  - state=IDLE, ptr=0, hold_cnt=0
  - gnt=0, gnt_id=0, out_data=0, out_valid=0, busy=0
- Requests are ignored during RELEASE. A requester dropping and re-raising req re-enters arbitration normally.

## Timing
- All outputs are registered except busy, which is a decode of the state register.
- Grant latency: req seen in IDLE at cycle 0 → gnt asserted in cycle 1 → first out_valid/out_data in cycle 2.
- Release: req[gnt_id] low in cycle n → gnt=0 and out_valid=0 in cycle n+1 (RELEASE), IDLE in cycle n+2, next gnt no earlier than cycle n+3.
- Minimum dead time between grants: 2 cycles with gnt=0.
- Preemption: a grant lasts exactly MAX_HOLD cycles when a competitor is present.
- Single-requester case: hold_cnt saturates and the grant continues indefinitely.
- Simultaneous timeout and req drop: treated as a normal release, with the same timing.

## Configuration
- ARB_TIMEOUT_EN defined: hold_cnt and the preemption path are compiled in, as described above.
- ARB_TIMEOUT_EN undefined: no hold_cnt. A grant is held until req[gnt_id] drops. MAX_HOLD is ignored. All other behaviour is identical.

## Test plan
All scenarios use NREQ=4, MAX_HOLD=4.
- Reset: rst=0 for 3 cycles with req=4'b1111 → gnt=0, out_valid=0, busy=0 throughout. First gnt=4'b0001 appears 1 cycle after rst returns to 1.
- Single request: req=4'b0100, din=4'b0100 → cycle 1: gnt=4'b0100, gnt_id=2. Cycle 2: out_valid=1, out_data=1. Drop req → next cycle gnt=0, out_valid=0, then 2 dead cycles.
- Rotation: req=4'b1111, each grantee drops req 2 cycles after its grant and re-raises it in RELEASE → grant order 0,1,2,3,0.
- Timeout (EN): req[0] and req[1] held high → gnt=4'b0001 for exactly 4 cycles, 2 cycles of gnt=0, then gnt=4'b0010 for 4 cycles, repeating.
- Timeout (not EN): same stimulus → gnt=4'b0001 held for the entire run.
- No competitor / reset mid-grant:
  - Only req[0] high for 20 cycles (EN) → gnt=4'b0001 continuous for 20 cycles.
  - rst=0 during GRANT of id 2 → next cycle all outputs 0. After release of reset with req=4'b1100, the grant goes to id 2 (ptr=0).
